// File: rtl/instr_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// dispatch_pkg
// Shared definitions for the instruction dispatcher:
//   - slot widths of the three functional units and the retire counter width
//   - bundle_t : one queue entry {dma, arith, cache}
//   - state_t  : dispatcher FSM states
//   - UNIT_*   : bit positions of each unit in per-unit masks
// ---------------------------------------------------------------------------
package dispatch_pkg;

    localparam int DMA_W   = 22;
    localparam int ARITH_W = 1;
    localparam int CACHE_W = 17;
    localparam int CNT_W   = 16;
    localparam int N_UNITS = 3;

    localparam int UNIT_DMA   = 0;
    localparam int UNIT_ARITH = 1;
    localparam int UNIT_CACHE = 2;

    typedef struct packed {
        logic [DMA_W-1:0]   dma;
        logic [ARITH_W-1:0] arith;
        logic [CACHE_W-1:0] cache;
    } bundle_t;

    typedef enum logic {
        IDLE  = 1'b0,   // no bundle held
        ISSUE = 1'b1    // bundle held, slots being issued or retiring
    } state_t;

endpackage

// File: rtl/instr_dispatch_if.sv
// ---------------------------------------------------------------------------
// instr_dispatch_if
// Bundles every non-clock/reset signal of the dispatcher:
//   queue side : q_empty, q_*_instr (head, fall-through), q_re (pop), halt
//   unit side  : <unit>_valid / <unit>_ready / <unit>_instr for dma, arith, cache
//   status     : busy, idle, retired_cnt
// Modports:
//   master : the dispatcher itself (drives q_re, the unit valids/instrs, status)
//   slave  : its environment (queue, host, functional units)
// ---------------------------------------------------------------------------
interface instr_dispatch_if;
    import dispatch_pkg::*;

    logic               q_empty;
    logic [DMA_W-1:0]   q_dma_instr;
    logic [ARITH_W-1:0] q_arith_instr;
    logic [CACHE_W-1:0] q_cache_instr;
    logic               q_re;
    logic               halt;

    logic               dma_valid;
    logic               dma_ready;
    logic [DMA_W-1:0]   dma_instr;
    logic               arith_valid;
    logic               arith_ready;
    logic [ARITH_W-1:0] arith_instr;
    logic               cache_valid;
    logic               cache_ready;
    logic [CACHE_W-1:0] cache_instr;

    logic               busy;
    logic               idle;
    logic [CNT_W-1:0]   retired_cnt;

    modport master (
        input  q_empty, q_dma_instr, q_arith_instr, q_cache_instr, halt,
        input  dma_ready, arith_ready, cache_ready,
        output q_re,
        output dma_valid, dma_instr, arith_valid, arith_instr, cache_valid, cache_instr,
        output busy, idle, retired_cnt
    );

    modport slave (
        output q_empty, q_dma_instr, q_arith_instr, q_cache_instr, halt,
        output dma_ready, arith_ready, cache_ready,
        input  q_re,
        input  dma_valid, dma_instr, arith_valid, arith_instr, cache_valid, cache_instr,
        input  busy, idle, retired_cnt
    );

endinterface

// File: rtl/instr_dispatch_issue_slot.sv
// ---------------------------------------------------------------------------
// issue_slot
// One issue lane of the dispatcher: holds a captured slot and presents it to
// its functional unit over valid/ready until accepted.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   capture     load slot_in into the hold register this posedge
//   slot_in     queue head slot for this unit (all-zero = NOP)
//   ready       unit ready
//   valid       unit valid (= pending bit)
//   instr       held slot, stable while valid
//   done        slot is finished by the end of this cycle (nothing pending,
//               or the pending slot is being accepted now)
// ---------------------------------------------------------------------------
module issue_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         capture,
    input  logic [W-1:0] slot_in,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] instr,
    output logic         done
);

    logic         pending_q, pending_d;
    logic [W-1:0] hold_q, hold_d;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        pending_d = pending_q;
        hold_d    = hold_q;
        if (capture) begin
            // Capture only happens once the previous slot is done, so it
            // never overwrites an un-accepted instruction. NOPs stay unissued.
            pending_d = |slot_in;
            hold_d    = slot_in;
        end else if (pending_q && ready) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            pending_q <= pending_d;
            hold_q    <= hold_d;
        end
    end

    assign valid = pending_q;
    assign instr = hold_q;
    assign done  = !pending_q || ready;

endmodule

// File: rtl/instr_dispatch.sv
// ---------------------------------------------------------------------------
// instr_dispatch
// Sequencer between the instruction queue and the dma / arithmetic / cache
// units. Pops one bundle at a time, issues each non-NOP slot to its unit and
// retires the bundle once every slot has been accepted. The next bundle is
// popped in the retiring cycle, so streams run without bubbles.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    instr_dispatch_if.master: queue pop, unit handshakes, halt, status
// ---------------------------------------------------------------------------
module instr_dispatch
    import dispatch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    instr_dispatch_if.master bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   retired_cnt_q, retired_cnt_d;
    logic [N_UNITS-1:0] slot_done;
    logic               retire;
    logic               q_re;

    issue_slot #(.W(DMA_W)) u_dma (
        .clk     (clk),
        .rst_n   (reset),
        .capture (q_re),
        .slot_in (bus.q_dma_instr),
        .ready   (bus.dma_ready),
        .valid   (bus.dma_valid),
        .instr   (bus.dma_instr),
        .done    (slot_done[UNIT_DMA])
    );

    issue_slot #(.W(ARITH_W)) u_arith (
        .clk     (clk),
        .rst_n   (reset),
        .capture (q_re),
        .slot_in (bus.q_arith_instr),
        .ready   (bus.arith_ready),
        .valid   (bus.arith_valid),
        .instr   (bus.arith_instr),
        .done    (slot_done[UNIT_ARITH])
    );

    issue_slot #(.W(CACHE_W)) u_cache (
        .clk     (clk),
        .rst_n   (reset),
        .capture (q_re),
        .slot_in (bus.q_cache_instr),
        .ready   (bus.cache_ready),
        .valid   (bus.cache_valid),
        .instr   (bus.cache_instr),
        .done    (slot_done[UNIT_CACHE])
    );

    // A held bundle retires in the cycle its last pending slot is accepted;
    // an all-NOP bundle has nothing pending and retires the cycle after capture.
    assign retire = (state_q == ISSUE) && (&slot_done);

    always_comb begin
        state_d       = state_q;
        retired_cnt_d = retired_cnt_q;
        q_re          = 1'b0;

        if (retire) begin
            retired_cnt_d = retired_cnt_q + 1'b1;
            state_d       = IDLE;
        end

        // Pop from IDLE, or in the retiring cycle for a back-to-back capture.
        // Held low during reset so the queue is never popped into a block
        // that cannot capture the entry.
        if (reset && !bus.halt && !bus.q_empty && ((state_q == IDLE) || retire)) begin
            q_re    = 1'b1;
            state_d = ISSUE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign bus.q_re        = q_re;
    assign bus.busy        = (state_q == ISSUE);
    assign bus.idle        = (state_q == IDLE) && bus.q_empty;
    assign bus.retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// ---------------------------------------------------------------------------
// tb_instr_dispatch
// Self-checking bench for instr_dispatch. The queue is a bench-side queue of
// bundles; a transaction-level model tracks, per unit, whether a slot of the
// held bundle is still outstanding and its value, plus the retired count.
// Every cycle the DUT outputs are compared with that model at the negedge.
// ---------------------------------------------------------------------------
module tb_instr_dispatch;
    import dispatch_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    instr_dispatch_if bus ();

    instr_dispatch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Queue contents and reference model.
    bundle_t     fifo[$];
    bit          held;
    bit          out_v[3];
    logic [21:0] out_val[3];
    int          ret_count;

    // Per-scenario statistics.
    int valid_cycles[3];
    int pops;

    function automatic logic [21:0] slot_of(bundle_t b, int u);
        case (u)
            0:       return b.dma;
            1:       return 22'(b.arith);
            default: return 22'(b.cache);
        endcase
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.dma   = ($urandom_range(0, 2) == 0) ? '0 : DMA_W'($urandom);
        b.arith = ARITH_W'($urandom);
        b.cache = ($urandom_range(0, 2) == 0) ? '0 : CACHE_W'($urandom);
        return b;
    endfunction

    function automatic bundle_t mk_bundle(logic [21:0] d, logic a, logic [16:0] c);
        bundle_t b;
        b.dma   = d;
        b.arith = a;
        b.cache = c;
        return b;
    endfunction

    task automatic drive_head();
        if (fifo.size() != 0) begin
            bus.q_empty       = 1'b0;
            bus.q_dma_instr   = fifo[0].dma;
            bus.q_arith_instr = fifo[0].arith;
            bus.q_cache_instr = fifo[0].cache;
        end else begin
            // Garbage on the head while empty must be ignored.
            bus.q_empty       = 1'b1;
            bus.q_dma_instr   = DMA_W'($urandom);
            bus.q_arith_instr = ARITH_W'($urandom);
            bus.q_cache_instr = CACHE_W'($urandom);
        end
    endtask

    task automatic set_ready(logic d, logic a, logic c);
        bus.dma_ready   = d;
        bus.arith_ready = a;
        bus.cache_ready = c;
    endtask

    task automatic model_clear();
        held      = 1'b0;
        ret_count = 0;
        for (int u = 0; u < 3; u++) begin
            out_v[u]   = 1'b0;
            out_val[u] = '0;
        end
    endtask

    task automatic clear_stats();
        pops = 0;
        for (int u = 0; u < 3; u++) valid_cycles[u] = 0;
    endtask

    // One clock: compare at the negedge, advance the model, then after the
    // posedge pop the queue if the DUT popped and present the new head.
    task automatic cycle();
        logic        vld[3];
        logic        rdy[3];
        logic [21:0] ins[3];
        bit          all_done;
        bit          exp_q_re;
        bit          popped;
        bundle_t     head;

        @(negedge clk);
        vld[0] = bus.dma_valid;   rdy[0] = bus.dma_ready;   ins[0] = bus.dma_instr;
        vld[1] = bus.arith_valid; rdy[1] = bus.arith_ready; ins[1] = 22'(bus.arith_instr);
        vld[2] = bus.cache_valid; rdy[2] = bus.cache_ready; ins[2] = 22'(bus.cache_instr);

        for (int u = 0; u < 3; u++) begin
            vectors++;
            if (vld[u] !== out_v[u]) begin
                miscompares++;
                $display("FAIL valid[%0d]: got %b expected %b at %0t", u, vld[u], out_v[u], $time);
            end
            if (out_v[u]) begin
                vectors++;
                if (ins[u] !== out_val[u]) begin
                    miscompares++;
                    $display("FAIL instr[%0d]: got %0h expected %0h at %0t", u, ins[u], out_val[u], $time);
                end
            end
        end

        all_done = held;
        for (int u = 0; u < 3; u++) if (out_v[u] && rdy[u] !== 1'b1) all_done = 1'b0;
        exp_q_re = !bus.halt && (fifo.size() != 0) && (!held || all_done);

        vectors++;
        if (bus.q_re !== exp_q_re) begin
            miscompares++;
            $display("FAIL q_re: got %b expected %b at %0t", bus.q_re, exp_q_re, $time);
        end
        vectors++;
        if (bus.busy !== held) begin
            miscompares++;
            $display("FAIL busy: got %b expected %b at %0t", bus.busy, held, $time);
        end
        vectors++;
        if (bus.idle !== (!held && fifo.size() == 0)) begin
            miscompares++;
            $display("FAIL idle: got %b expected %b at %0t", bus.idle, (!held && fifo.size() == 0), $time);
        end
        vectors++;
        if (bus.retired_cnt !== CNT_W'(ret_count)) begin
            miscompares++;
            $display("FAIL retired_cnt: got %0h expected %0h at %0t", bus.retired_cnt, CNT_W'(ret_count), $time);
        end

        // Advance the model.
        for (int u = 0; u < 3; u++) begin
            if (vld[u] === 1'b1) valid_cycles[u]++;
            if (out_v[u] && rdy[u] === 1'b1) out_v[u] = 1'b0;
        end
        if (held && all_done) begin
            ret_count++;
            held = 1'b0;
        end
        if (exp_q_re) begin
            head = fifo[0];
            held = 1'b1;
            for (int u = 0; u < 3; u++) begin
                out_val[u] = slot_of(head, u);
                out_v[u]   = (slot_of(head, u) != '0);
            end
        end
        popped = (bus.q_re === 1'b1);
        if (popped) pops++;

        @(posedge clk);
        #1;
        if (popped && fifo.size() != 0) void'(fifo.pop_front());
        drive_head();
    endtask

    task automatic drain();
        int budget = 0;
        set_ready(1'b1, 1'b1, 1'b1);
        bus.halt = 1'b0;
        while ((fifo.size() != 0 || held) && budget < 50) begin
            cycle();
            budget++;
        end
        cycle();
        vectors++;
        if (budget >= 50) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d cycles limit 50", budget);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        bus.halt = 1'b0;
        set_ready(1'b1, 1'b1, 1'b1);
        fifo.delete();
        model_clear();
        drive_head();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Reset values, with a non-empty queue so q_re gating is observable.
    task automatic test_reset();
        reset    = 1'b0;
        bus.halt = 1'b0;
        set_ready(1'b1, 1'b1, 1'b1);
        model_clear();
        fifo.push_back(mk_bundle(22'h2a, 1'b1, 17'h11));
        drive_head();
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.dma_valid, bus.arith_valid, bus.cache_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_valids: got %b expected 000", {bus.dma_valid, bus.arith_valid, bus.cache_valid});
        end
        vectors++;
        if (bus.q_re !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_q_re: got %b expected 0", bus.q_re);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.idle !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got busy=%b idle=%b expected busy=0 idle=0", bus.busy, bus.idle);
        end
        vectors++;
        if (bus.retired_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0h expected 0", bus.retired_cnt);
        end
        reset = 1'b1;
        drain();
    endtask

    // Three bundles, all ready: pops on three consecutive cycles.
    task automatic test_stream();
        do_reset();
        clear_stats();
        for (int i = 0; i < 3; i++) fifo.push_back(mk_bundle(22'(i + 1), 1'b1, 17'(i + 7)));
        drive_head();
        repeat (3) cycle();
        vectors++;
        if (pops != 3) begin
            miscompares++;
            $display("FAIL stream_pops: got %0d expected 3", pops);
        end
        repeat (3) cycle();
        vectors++;
        if (bus.retired_cnt !== 16'd3 || bus.idle !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_end: got cnt=%0d idle=%b expected cnt=3 idle=1", bus.retired_cnt, bus.idle);
        end
    endtask

    // dma stalls four cycles; arith/cache accepted once; next pop waits.
    task automatic test_stall();
        clear_stats();
        fifo.push_back(mk_bundle(22'h1, 1'b1, 17'h5));
        fifo.push_back(mk_bundle(22'h0, 1'b1, 17'h0));
        drive_head();
        set_ready(1'b0, 1'b1, 1'b1);
        repeat (5) cycle();
        vectors++;
        if (pops != 1) begin
            miscompares++;
            $display("FAIL stall_no_pop: got %0d pops expected 1", pops);
        end
        bus.dma_ready = 1'b1;
        cycle();
        vectors++;
        if (valid_cycles[0] != 5 || valid_cycles[1] != 1 || valid_cycles[2] != 1) begin
            miscompares++;
            $display("FAIL stall_valid_cycles: got %0d/%0d/%0d expected 5/1/1",
                     valid_cycles[0], valid_cycles[1], valid_cycles[2]);
        end
        vectors++;
        if (pops != 2) begin
            miscompares++;
            $display("FAIL stall_pop_after_accept: got %0d pops expected 2", pops);
        end
        drain();
    endtask

    // All-NOP bundle: no valid, counted, next bundle popped next cycle.
    task automatic test_all_nop();
        int base = ret_count;
        clear_stats();
        fifo.push_back(mk_bundle(22'h0, 1'b0, 17'h0));
        fifo.push_back(mk_bundle(22'h3ffff, 1'b0, 17'h1ffff));
        drive_head();
        set_ready(1'b1, 1'b1, 1'b1);
        repeat (2) cycle();
        vectors++;
        if (valid_cycles[0] + valid_cycles[1] + valid_cycles[2] != 0) begin
            miscompares++;
            $display("FAIL nop_valids: got %0d valid cycles expected 0",
                     valid_cycles[0] + valid_cycles[1] + valid_cycles[2]);
        end
        vectors++;
        if (bus.retired_cnt !== CNT_W'(base + 1) || pops != 2) begin
            miscompares++;
            $display("FAIL nop_retire: got cnt=%0d pops=%0d expected cnt=%0d pops=2",
                     bus.retired_cnt, pops, base + 1);
        end
        drain();
    endtask

    // halt during ISSUE: held bundle retires, nothing else pops until release.
    task automatic test_halt();
        clear_stats();
        for (int i = 0; i < 3; i++) fifo.push_back(mk_bundle(22'h100 + 22'(i), 1'b1, 17'h20));
        drive_head();
        set_ready(1'b0, 1'b1, 1'b1);
        cycle();
        bus.halt = 1'b1;
        cycle();
        bus.dma_ready = 1'b1;
        repeat (5) cycle();
        vectors++;
        if (pops != 1 || fifo.size() != 2) begin
            miscompares++;
            $display("FAIL halt_pops: got pops=%0d left=%0d expected pops=1 left=2", pops, fifo.size());
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.idle !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_state: got busy=%b idle=%b expected busy=0 idle=0", bus.busy, bus.idle);
        end
        bus.halt = 1'b0;
        cycle();
        vectors++;
        if (pops != 2) begin
            miscompares++;
            $display("FAIL halt_resume: got %0d pops expected 2", pops);
        end
        drain();
    endtask

    // Asynchronous reset while a cache slot is waiting.
    task automatic test_reset_mid_issue();
        fifo.push_back(mk_bundle(22'h0, 1'b0, 17'h1abc));
        fifo.push_back(mk_bundle(22'h3, 1'b1, 17'h2));
        drive_head();
        set_ready(1'b1, 1'b1, 1'b0);
        cycle();
        vectors++;
        if (bus.cache_valid !== 1'b1 || bus.cache_instr !== 17'h1abc) begin
            miscompares++;
            $display("FAIL mid_pre: got valid=%b instr=%0h expected valid=1 instr=1abc",
                     bus.cache_valid, bus.cache_instr);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.dma_valid, bus.arith_valid, bus.cache_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_valids: got %b expected 000", {bus.dma_valid, bus.arith_valid, bus.cache_valid});
        end
        vectors++;
        if (bus.retired_cnt !== '0 || bus.busy !== 1'b0 || bus.q_re !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_state: got cnt=%0h busy=%b q_re=%b expected 0/0/0",
                     bus.retired_cnt, bus.busy, bus.q_re);
        end
        @(posedge clk);
        #1;
        fifo.delete();
        model_clear();
        drive_head();
        set_ready(1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        drain();
    endtask

    // Random traffic with random readies and occasional halt.
    task automatic test_random();
        int pushed = 0;
        int budget = 0;
        while ((pushed < 200 || fifo.size() != 0 || held) && budget < 6000) begin
            if (pushed < 200 && $urandom_range(0, 1) == 1) begin
                fifo.push_back(rand_bundle());
                pushed++;
                drive_head();
            end
            set_ready(1'($urandom), 1'($urandom), 1'($urandom));
            bus.halt = ($urandom_range(0, 7) == 0);
            cycle();
            budget++;
        end
        vectors++;
        if (budget >= 6000) begin
            miscompares++;
            $display("FAIL random_timeout: got %0d cycles limit 6000", budget);
        end
        drain();
    endtask

    // 65536 all-NOP bundles: the counter wraps to zero.
    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 65536; i++) fifo.push_back(mk_bundle(22'h0, 1'b0, 17'h0));
        drive_head();
        repeat (65536) cycle();
        vectors++;
        if (bus.retired_cnt !== 16'hffff) begin
            miscompares++;
            $display("FAIL wrap_pre: got %0h expected ffff", bus.retired_cnt);
        end
        cycle();
        vectors++;
        if (bus.retired_cnt !== 16'h0000 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap: got cnt=%0h busy=%b expected cnt=0 busy=0", bus.retired_cnt, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_all_nop();
        test_halt();
        test_reset_mid_issue();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got time %0t limit 3000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
